// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver (sync, glitch filter, frame FSM, timeout); ports clk_vga, rst, ps2_clk, ps2_dat -> data, valid, err, err_code, busy
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t      state, state_n;
  logic [1:0]  clk_s, dat_s;
  logic [7:0]  fcnt;
  logic        filt, filt_d, strobe;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic        par;
  logic [19:0] tcnt;
  logic        d, to, odd, ok, perr, ferr;
  assign d    = dat_s[1];
  assign busy = state != IDLE;
  assign odd  = ^{shreg, par};
  assign ok   = strobe && state == STOP && odd && d;
  assign perr = strobe && state == STOP && !odd;
  assign ferr = strobe && state == STOP && odd && !d;
  // a strobe in the same cycle always beats the timeout
  assign to   = busy && !strobe && tcnt == 20'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    if (strobe)
      unique case (state)
        IDLE:    state_n = d ? IDLE : DATA;
        DATA:    state_n = bcnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
    else if (to)
      state_n = IDLE;
  end
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state    <= IDLE;
      clk_s    <= 2'b11;
      dat_s    <= 2'b11;
      fcnt     <= '0;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      strobe   <= 1'b0;
      bcnt     <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state  <= state_n;
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_dat};
      // filtered clock flips only after FILTER_LEN consecutive disagreeing samples
      if (clk_s[1] == filt) fcnt <= '0;
      else if (fcnt == 8'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 8'd1;
      filt_d <= filt;
      strobe <= filt_d && !filt;
      tcnt   <= (strobe || !busy) ? '0 : tcnt + 20'd1;
      if (strobe && state == IDLE && !d) begin
        bcnt  <= '0;
        shreg <= '0;
      end
      if (strobe && state == DATA) begin
        shreg <= {d, shreg[7:1]};
        bcnt  <= bcnt + 3'd1;
      end
      if (strobe && state == PARITY) par <= d;
      valid    <= ok;
      err      <= perr || ferr || to;
      data     <= ok ? shreg : data;
      err_code <= perr ? 2'b01 : ferr ? 2'b10 : to ? 2'b11 : err_code;
    end
  end
endmodule
